aes_iter_core: RTL and testbench

- Iterative AES-128 encryption engine: one round datapath reused over NUM_ROUNDS cycles, with an on-the-fly key schedule and a valid/ready handshake on both sides.
- Generalises the fixed single-round, constant-whitened wrapper into a multi-cycle core with configurable round count and whitening constant.
- Sits between the key/plaintext source and ciphertext consumer in the AES subsystem; one block in flight at a time.

---
 rtl/aes_iter_pkg.sv | 71 +++++++
 rtl/aes_round_comb.sv | 42 ++++
 rtl/aes_iter_core.sv | 130 +++++++++++++
 tb/tb_aes_iter_core.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_iter_pkg.sv
// Shared AES-128 tables, FSM state type and byte/word helpers for the
// iterative core.
package aes_iter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [0:255][7:0] SBOX = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [1:10][7:0] RCON = {
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [7:0] sbox_lookup(input logic [7:0] b);
        return SBOX[b];
    endfunction

    // Indices outside 1..10 never reach the key schedule; return 0 for them.
    function automatic logic [7:0] rcon_lookup(input logic [3:0] idx);
        logic [7:0] r;
        r = 8'h00;
        if (idx >= 4'd1 && idx <= 4'd10) begin
            r = RCON[idx];
        end
        return r;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_lookup(w[31:24]), sbox_lookup(w[23:16]),
                sbox_lookup(w[15:8]),  sbox_lookup(w[7:0])};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] b0, b1, b2, b3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        return {b0, b1, b2, b3};
    endfunction

endpackage

// File: rtl/aes_round_comb.sv
// One combinational AES encryption round: SubBytes, ShiftRows, optional
// MixColumns (skipped on the final round) and AddRoundKey.
module aes_round_comb
    import aes_iter_pkg::*;
(
    input  logic [127:0] st_i,
    input  logic [127:0] rk_i,
    input  logic         last_i,
    output logic [127:0] st_o
);

    logic [127:0] sb;
    logic [127:0] sr;
    logic [127:0] mc;

    // Byte i sits at bits [127-8i -: 8]; column c holds bytes 4c..4c+3.
    always_comb begin
        sb = '0;
        for (int i = 0; i < 16; i++) begin
            sb[127-8*i -: 8] = sbox_lookup(st_i[127-8*i -: 8]);
        end
    end

    always_comb begin
        sr = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[127-8*(4*c+r) -: 8] = sb[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end
    end

    always_comb begin
        mc = '0;
        for (int c = 0; c < 4; c++) begin
            mc[127-32*c -: 32] = mix_column(sr[127-32*c -: 32]);
        end
    end

    assign st_o = (last_i ? sr : mc) ^ rk_i;

endmodule

// File: rtl/aes_iter_core.sv
// Iterative AES-128 encryption core, one round per clock with on-the-fly key
// expansion. Optional abort input enabled by defining AES_ITER_ABORT_EN.
module aes_iter_core
    import aes_iter_pkg::*;
#(
    parameter int           NUM_ROUNDS = 10,
    parameter logic [127:0] KEY_XOR    = 128'h0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] key,
    input  logic [127:0] pt,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] ct,
    output logic         busy,
`ifdef AES_ITER_ABORT_EN
    input  logic         abort,
`endif
    output logic [1:0]   dbg_state
);

    if (NUM_ROUNDS < 1 || NUM_ROUNDS > 10) begin : g_bad_rounds
        $error("aes_iter_core: NUM_ROUNDS must be within 1..10");
    end

    localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);

    state_t       state_q, state_d;
    logic [127:0] rk_q, rk_d;
    logic [127:0] st_q, st_d;
    logic [127:0] ct_q, ct_d;
    logic [3:0]   rnd_q, rnd_d;

    logic         abort_w;
    logic         last_rnd;
    logic [127:0] rk_next;
    logic [127:0] round_out;
    logic [31:0]  ks_temp;
    logic [31:0]  w0, w1, w2, w3;

`ifdef AES_ITER_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    assign last_rnd = (rnd_q == LAST_RND);

    // rk_q holds round key rnd-1; derive round key rnd for this cycle.
    always_comb begin
        ks_temp = sub_word({rk_q[23:0], rk_q[31:24]}) ^ {rcon_lookup(rnd_q), 24'h0};
        w0      = rk_q[127:96] ^ ks_temp;
        w1      = rk_q[95:64]  ^ w0;
        w2      = rk_q[63:32]  ^ w1;
        w3      = rk_q[31:0]   ^ w2;
        rk_next = {w0, w1, w2, w3};
    end

    aes_round_comb u_round (
        .st_i   (st_q),
        .rk_i   (rk_next),
        .last_i (last_rnd),
        .st_o   (round_out)
    );

    always_comb begin
        state_d = state_q;
        rk_d    = rk_q;
        st_d    = st_q;
        ct_d    = ct_q;
        rnd_d   = rnd_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    rk_d    = key ^ KEY_XOR;
                    st_d    = pt ^ key ^ KEY_XOR;
                    rnd_d   = 4'd1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (abort_w) begin
                    state_d = IDLE;
                end else begin
                    rk_d  = rk_next;
                    st_d  = round_out;
                    rnd_d = rnd_q + 4'd1;
                    if (last_rnd) begin
                        ct_d    = round_out;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (abort_w || out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rk_q    <= '0;
            st_q    <= '0;
            ct_q    <= '0;
            rnd_q   <= '0;
        end else begin
            state_q <= state_d;
            rk_q    <= rk_d;
            st_q    <= st_d;
            ct_q    <= ct_d;
            rnd_q   <= rnd_d;
        end
    end

    // in_valid/in_ready and out_valid/out_ready each complete a transfer on
    // a rising edge where both are high; neither valid may depend on ready.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == RUN) || (state_q == DONE);
    assign ct        = ct_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_aes_iter_core.sv
// Directed bench for aes_iter_core using FIPS-197 vectors on a default
// instance and on a KEY_XOR-whitened instance.
module tb_aes_iter_core;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KX     = 128'hc2f45dfa8acd3f4da3dcfe8a93cefa0a;

    logic         clk = 1'b0;
    logic         rst = 1'b0;

    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] key = '0;
    logic [127:0] pt = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] ct;
    logic         busy;
    logic         abort = 1'b0;
    logic [1:0]   dbg_state;

    logic         kx_in_valid = 1'b0;
    logic         kx_in_ready;
    logic [127:0] kx_key = '0;
    logic [127:0] kx_pt = '0;
    logic         kx_out_valid;
    logic         kx_out_ready = 1'b0;
    logic [127:0] kx_ct;
    logic         kx_busy;
    logic         kx_abort = 1'b0;
    logic [1:0]   kx_dbg_state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    aes_iter_core #(.NUM_ROUNDS(10), .KEY_XOR(128'h0)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .key       (key),
        .pt        (pt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ct        (ct),
        .busy      (busy),
`ifdef AES_ITER_ABORT_EN
        .abort     (abort),
`endif
        .dbg_state (dbg_state)
    );

    aes_iter_core #(.NUM_ROUNDS(10), .KEY_XOR(KX)) u_dut_kx (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (kx_in_valid),
        .in_ready  (kx_in_ready),
        .key       (kx_key),
        .pt        (kx_pt),
        .out_valid (kx_out_valid),
        .out_ready (kx_out_ready),
        .ct        (kx_ct),
        .busy      (kx_busy),
`ifdef AES_ITER_ABORT_EN
        .abort     (kx_abort),
`endif
        .dbg_state (kx_dbg_state)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [127:0] k, input logic [127:0] p);
        key      = k;
        pt       = p;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Cycles from the acceptance edge until out_valid; -1 if it never rises.
    task automatic wait_out(output int lat);
        lat = -1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (out_valid === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++;
        if (ct !== 128'h0) begin errors++; $display("FAIL reset_ct got %h want 0", ct); end
        checks++;
        if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", dbg_state); end
    endtask

    task automatic test_fips_c1();
        int lat;
        accept(C1_KEY, C1_PT);
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++; $display("FAIL c1_run_flags got busy=%b in_ready=%b want busy=1 in_ready=0", busy, in_ready);
        end
        wait_out(lat);
        checks++;
        if (lat !== 10) begin errors++; $display("FAIL c1_latency got %0d want 10", lat); end
        checks++;
        if (ct !== C1_CT) begin errors++; $display("FAIL c1_ct got %h want %h", ct, C1_CT); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL c1_release got ov=%b ir=%b busy=%b want 0 1 0", out_valid, in_ready, busy);
        end
        checks++;
        if (ct !== C1_CT) begin errors++; $display("FAIL c1_ct_kept got %h want %h", ct, C1_CT); end
    endtask

    task automatic test_fips_b_hold();
        int lat;
        accept(B_KEY, B_PT);
        wait_out(lat);
        checks++;
        if (lat !== 10) begin errors++; $display("FAIL b_latency got %0d want 10", lat); end
        key      = C1_KEY;
        pt       = C1_PT;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || ct !== B_CT) begin
                errors++; $display("FAIL b_hold cycle %0d got ov=%b ir=%b ct=%h want 1 0 %h", i, out_valid, in_ready, ct, B_CT);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || ct !== B_CT) begin
            errors++; $display("FAIL b_release got ir=%b ov=%b ct=%h want 1 0 %h", in_ready, out_valid, ct, B_CT);
        end
        tick();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL b_ignored_in_valid got busy=%b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        int acc_cyc[2];
        logic [127:0] ct_got[2];
        int n_acc = 0;
        int n_out = 0;
        int cyc = 0;
        logic acc_now;
        acc_cyc[0] = 0;
        acc_cyc[1] = 0;
        ct_got[0]  = '0;
        ct_got[1]  = '0;
        out_ready = 1'b1;
        key       = C1_KEY;
        pt        = C1_PT;
        in_valid  = 1'b1;
        for (int i = 0; i < 40 && n_out < 2; i++) begin
            acc_now = in_valid && in_ready;
            if (out_valid === 1'b1) begin
                ct_got[n_out] = ct;
                n_out++;
            end
            tick();
            cyc++;
            if (acc_now && n_acc < 2) begin
                acc_cyc[n_acc] = cyc;
                n_acc++;
                if (n_acc == 1) begin
                    key = B_KEY;
                    pt  = B_PT;
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (n_acc !== 2 || n_out !== 2) begin errors++; $display("FAIL b2b_counts got acc=%0d out=%0d want 2 2", n_acc, n_out); end
        checks++;
        if (acc_cyc[1] - acc_cyc[0] !== 12) begin
            errors++; $display("FAIL b2b_spacing got %0d want 12", acc_cyc[1] - acc_cyc[0]);
        end
        checks++;
        if (ct_got[0] !== C1_CT) begin errors++; $display("FAIL b2b_ct0 got %h want %h", ct_got[0], C1_CT); end
        checks++;
        if (ct_got[1] !== B_CT) begin errors++; $display("FAIL b2b_ct1 got %h want %h", ct_got[1], B_CT); end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        accept(C1_KEY, C1_PT);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL midrun_reset_flags got ir=%b ov=%b busy=%b want 1 0 0", in_ready, out_valid, busy);
        end
        checks++;
        if (ct !== 128'h0) begin errors++; $display("FAIL midrun_reset_ct got %h want 0", ct); end
        accept(C1_KEY, C1_PT);
        wait_out(lat);
        checks++;
        if (lat !== 10 || ct !== C1_CT) begin
            errors++; $display("FAIL after_reset_c1 got lat=%0d ct=%h want 10 %h", lat, ct, C1_CT);
        end
        rst       = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        tick();
        rst       = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || ct !== 128'h0) begin
            errors++; $display("FAIL done_reset got ir=%b ov=%b ct=%h want 1 0 0", in_ready, out_valid, ct);
        end
        tick();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL done_reset_no_accept got busy=%b want 0", busy); end
    endtask

    task automatic test_key_xor();
        int lat = -1;
        kx_key      = C1_KEY ^ KX;
        kx_pt       = C1_PT;
        kx_in_valid = 1'b1;
        tick();
        kx_in_valid = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (kx_out_valid === 1'b1) begin
                lat = i;
                break;
            end
        end
        checks++;
        if (lat !== 10) begin errors++; $display("FAIL kx_latency got %0d want 10", lat); end
        checks++;
        if (kx_ct !== C1_CT) begin errors++; $display("FAIL kx_ct got %h want %h", kx_ct, C1_CT); end
        kx_out_ready = 1'b1;
        tick();
        kx_out_ready = 1'b0;
        checks++;
        if (kx_in_ready !== 1'b1) begin errors++; $display("FAIL kx_release got ir=%b want 1", kx_in_ready); end
    endtask

`ifdef AES_ITER_ABORT_EN
    task automatic test_abort();
        int lat;
        int pulses = 0;
        accept(C1_KEY, C1_PT);
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL abort_flags got ir=%b ov=%b busy=%b want 1 0 0", in_ready, out_valid, busy);
        end
        for (int i = 0; i < 15; i++) begin
            tick();
            if (out_valid === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0) begin errors++; $display("FAIL abort_no_output got %0d pulses want 0", pulses); end
        abort = 1'b1;
        accept(C1_KEY, C1_PT);
        abort = 1'b0;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL abort_idle_accept got busy=%b want 1", busy); end
        wait_out(lat);
        checks++;
        if (lat !== 10 || ct !== C1_CT) begin
            errors++; $display("FAIL abort_then_c1 got lat=%0d ct=%h want 10 %h", lat, ct, C1_CT);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL abort_done got ov=%b ir=%b want 0 1", out_valid, in_ready);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_fips_c1();
        test_fips_b_hold();
        test_back_to_back();
        test_reset_mid_run();
        test_key_xor();
`ifdef AES_ITER_ABORT_EN
        test_abort();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
